// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the parallel-to-serial shifter.
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Purpose: parallel word to one-bit serial stream with a one-word holding slot.
// Latency: first bit on dout the cycle after acceptance; back-to-back words stream without gaps.
// Backpressure: in_ready drops while the holding slot is full; bit_en low freezes the current bit.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             hold_full, hold_full_nxt;
    logic [WIDTH-1:0] shreg_shifted;
    logic             accept, advance, word_done;

    assign dout_valid = (state == SHIFT);
    assign dout_last  = dout_valid && (cnt == LAST_IDX);
    assign dout       = dout_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign in_ready   = !hold_full;
    assign busy       = dout_valid || hold_full;

    assign accept    = in_valid && in_ready;
    assign advance   = dout_valid && bit_en;
    assign word_done = advance && dout_last;

    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        hold_nxt      = hold;
        cnt_nxt       = cnt;
        hold_full_nxt = hold_full;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = in_data;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (word_done) begin
                    cnt_nxt = '0;
                    // A held word takes priority; accept cannot coincide with a full slot.
                    if (hold_full) begin
                        shreg_nxt     = hold;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        shreg_nxt = in_data;
                    end else begin
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                    end
                end else begin
                    if (advance) begin
                        shreg_nxt = shreg_shifted;
                        cnt_nxt   = cnt + CW'(1);
                    end
                    if (accept) begin
                        hold_nxt      = in_data;
                        hold_full_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            shreg     <= shreg_nxt;
            hold      <= hold_nxt;
            cnt       <= cnt_nxt;
            hold_full <= hold_full_nxt;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboarded bench: an MSB-first and an LSB-first serializer driven with directed words.
module tb_bit_serializer;

    typedef struct {
        logic d;
        logic last;
        int   hold;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_en;
    logic [7:0] in_data1, in_data2;
    logic       in_valid1, in_valid2;
    logic       in_ready1, in_ready2;
    logic       dout1, dout2, dv1, dv2, dl1, dl2, busy1, busy2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   total = 0;
    int   passed = 0;
    int   hcnt1 = 0, hcnt2 = 0, rises1 = 0, det = 0, r0;
    logic pv1 = 1'b0;
    logic [2:0] hist = 3'b000;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .bit_en(bit_en), .dout(dout1), .dout_valid(dv1),
        .dout_last(dl1), .busy(busy1)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .bit_en(bit_en), .dout(dout2), .dout_valid(dv2),
        .dout_last(dl2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected bits of one word; stall_idx marks the bit held for four cycles.
    task automatic push_word(input int sel, input logic [7:0] w, input int stall_idx);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.d    = (sel == 1) ? w[7-i] : w[i];
            e.last = (i == 7);
            e.hold = (i == stall_idx) ? 4 : 1;
            if (sel == 1) q1.push_back(e);
            else q2.push_back(e);
        end
    endtask

    // Call #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int sel, input logic [7:0] w, input int stall_idx);
        int   n;
        logic ok;
        n = 0;
        if (sel == 1) begin in_data1 = w; in_valid1 = 1'b1; end
        else begin in_data2 = w; in_valid2 = 1'b1; end
        do begin
            ok = (sel == 1) ? in_ready1 : in_ready2;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (sel == 1) in_valid1 = 1'b0;
        else in_valid2 = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        else push_word(sel, w, stall_idx);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy1 || busy2) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy1 || busy2) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            pv1   = 1'b0;
            hcnt1 = 0;
        end else begin
            if (dv1) begin
                hcnt1++;
                if (!pv1) rises1++;
            end else begin
                chk("idle_dout1", dout1, 0);
                chk("idle_last1", dl1, 0);
            end
            pv1 = dv1;
            if (dv1 && bit_en) begin
                if (q1.size() == 0) chk("unexpected_bit1", 32'd1, 32'd0);
                else begin
                    e1 = q1.pop_front();
                    chk("dout1", dout1, e1.d);
                    chk("dout_last1", dl1, e1.last);
                    chk("bit_hold1", hcnt1, e1.hold);
                    hist = {hist[1:0], dout1};
                    if (hist == 3'b101) det++;
                end
                hcnt1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hcnt2 = 0;
        end else begin
            if (dv2) hcnt2++;
            if (dv2 && bit_en) begin
                if (q2.size() == 0) chk("unexpected_bit2", 32'd1, 32'd0);
                else begin
                    e2 = q2.pop_front();
                    chk("dout2", dout2, e2.d);
                    chk("dout_last2", dl2, e2.last);
                    chk("bit_hold2", hcnt2, e2.hold);
                end
                hcnt2 = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bit_en = 1'b1;
        in_data1 = '0; in_data2 = '0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout1, 0);
        chk("rst_dout_valid", dv1, 0);
        chk("rst_dout_last", dl1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_in_ready2", in_ready2, 1);

        // Single word, accepted on the first edge after release.
        @(posedge clk);
        #1 reset = 1'b0;
        send(1, 8'hA0, -1);
        chk("a0_first_valid", dv1, 1);
        chk("a0_first_bit", dout1, 1);
        repeat (7) @(posedge clk);
        #1;
        chk("a0_last_flag", dl1, 1);
        @(posedge clk);
        #1;
        chk("a0_idle_after", dv1, 0);

        // Back-to-back words stream without gaps; slot stays full until the handover.
        wait_idle();
        r0 = rises1;
        send(1, 8'hA5, -1);
        send(1, 8'h5A, -1);
        chk("b2b_ready_low", in_ready1, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_ready_still_low", in_ready1, 0);
        @(posedge clk);
        #1;
        chk("b2b_ready_back", in_ready1, 1);
        wait_idle();
        chk("b2b_contiguous", rises1 - r0, 1);

        // Stall on bit 2 of C3 while a word is accepted into the holding slot.
        send(1, 8'hC3, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bit_en = 1'b0;
        send(1, 8'h81, -1);
        chk("stall_hold_full", in_ready1, 0);
        repeat (2) @(posedge clk);
        #1 bit_en = 1'b1;
        wait_idle();

        // Detector stream 05, 00: exactly one 101 occurrence.
        hist = 3'b000;
        det  = 0;
        send(1, 8'h05, -1);
        send(1, 8'h00, -1);
        wait_idle();
        chk("detector_pulses", det, 1);

        // Reset during bit 4 with the holding slot full.
        send(1, 8'hA5, -1);
        send(1, 8'h5A, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy1, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_dout", dout1, 0);
        chk("mid_rst_valid", dv1, 0);
        chk("mid_rst_last", dl1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_ready", in_ready1, 1);
        q1.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        send(1, 8'h3C, -1);
        chk("post_rst_valid", dv1, 1);
        wait_idle();

        // LSB-first instance.
        send(2, 8'h01, -1);
        chk("lsb_first_bit", dout2, 1);
        send(2, 8'hB4, -1);
        wait_idle();

        @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select the shift order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  SHALL carry the parallel word offered upstream.
REQ-006 in_valid  input  1  SHALL indicate that in_data is valid.
REQ-007 in_ready  output  1  SHALL indicate that a word can be accepted this cycle.
REQ-008 bit_en  input  1  SHALL permit the serial stream to advance one bit per cycle when high.
REQ-009 dout  output  1  SHALL carry the serial bit, feeding the downstream sequence detector's din.
REQ-010 dout_valid  output  1  SHALL be high while dout carries a word bit.
REQ-011 dout_last  output  1  SHALL be high while dout carries the final bit of a word.
REQ-012 busy  output  1  SHALL be high when the shifter or the holding register is occupied.

Function
REQ-013 Internal storage SHALL be one shift register, one bit counter (0..WIDTH-1) and one WIDTH-bit holding register with a full flag.
REQ-014 The shifter SHALL have two states: IDLE (empty) and SHIFT (holding a word).
REQ-015 in_ready SHALL equal the inverse of the holding-full flag, independent of in_valid.
REQ-016 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-017 An accepted word SHALL load directly into the shifter if the shifter is IDLE, or is presenting its last bit with bit_en high; otherwise it SHALL enter the holding register.
REQ-018 A word loaded into the shifter SHALL present its first bit on dout, with dout_valid high, in the cycle immediately after the load edge, regardless of bit_en.
REQ-019 dout SHALL advance to the next bit on each edge where dout_valid and bit_en are both high.
REQ-020 dout SHALL hold the same bit while bit_en is low; holding-register acceptance SHALL still be allowed during that time.
REQ-021 dout_last SHALL be high exactly when the counter equals WIDTH-1 and dout_valid is high.
REQ-022 When the last bit advances and the holding register is full, the holding word SHALL load into the shifter on that edge, leaving no gap cycle, and holding-full SHALL clear.
REQ-023 When the last bit advances and no word is available, the shifter SHALL return to IDLE with dout=0 and dout_valid=0.
REQ-024 In IDLE, dout, dout_valid and dout_last SHALL be 0.
REQ-025 The counter SHALL wrap from WIDTH-1 to 0 on every word boundary.

Reset
REQ-026 Reset SHALL force: IDLE, counter=0, holding-full=0, dout=0, dout_valid=0, dout_last=0, busy=0, in_ready=1.
REQ-027 Reset asserted mid-word SHALL discard the shifter and holding contents; no partial word SHALL resume after release.
REQ-028 The first acceptance after reset SHALL be possible on the first rising edge with reset low.

Structure
REQ-029 State encodings (IDLE, SHIFT) SHALL reside in the shared package, together with the default WIDTH constant.
REQ-030 The design SHALL be one module with no sub-modules; the holding register SHALL NOT be split into a separate FIFO block.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, bit_en=1; accept 8'hA0 -> dout = 1,0,1,0,0,0,0,0 on cycles N+1..N+8; dout_last only on N+8; dout_valid=0 on N+9.
REQ-032 Words 8'hA5 then 8'h5A offered back-to-back -> 16 contiguous dout_valid cycles; in_ready low from the second acceptance until the first word's last bit advances.
REQ-033 Stream 8'h05, 8'h00 into the downstream detector with MSB_FIRST=1 -> the 101 pattern at bits 5..7 yields exactly one detector pulse; serializer bits match the expected sequence.
REQ-034 bit_en low for 3 cycles after bit 2 of 8'hC3 -> dout holds bit 2 for 4 cycles total; the remaining bits follow unchanged.
REQ-035 Reset pulsed during bit 4 with the holding register full -> all outputs go 0 immediately, in_ready=1; the next accepted word is serialized from its first bit.
REQ-036 MSB_FIRST=0; accept 8'h01 -> dout = 1,0,0,0,0,0,0,0.
